// File: rtl/uart_word_tx_if.sv
// Handshake and serial-output bundle between the debug send controller and uart_word_tx.
// The master side drives tx_start and tx_data, and observes tx, tx_done and busy.
// The slave side (the transmitter) samples the request and drives the line and status.
interface uart_word_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tx_start;  // level request, sampled only when the transmitter is idle
    logic [DATA_WIDTH-1:0] tx_data;   // word to send, captured on the accept edge
    logic                  tx;        // serial line, idle high
    logic                  tx_done;   // one-cycle pulse when the whole word has been sent
    logic                  busy;      // high from the accept edge until the return to IDLE

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_done,
        input  busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_done,
        output busy
    );
endinterface

// File: rtl/uart_word_tx.sv
// Word-to-UART serialiser: sends DATA_WIDTH/8 back-to-back 8N1 frames, LSB byte and LSB bit first.
// Latency: tx_done starts NBYTES*10*CLKS_PER_BIT cycles after the accept edge; every output is registered.
// Backpressure: tx_start is a level request, sampled only on entry to or while in IDLE; a request held high
//               is re-accepted HOLDOFF+1 cycles after the tx_done cycle begins.
// Ports: clk, reset (async, active-high); bus (slave modport): tx_start, tx_data in; tx, tx_done, busy out.
module uart_word_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 5208,
    parameter int HOLDOFF      = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_word_tx_if.slave  bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNTW   = $clog2(CLKS_PER_BIT);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int HW     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BYTE_LAST = BW'(NBYTES - 1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNTW-1:0]       r_cnt;
    logic [CNTW-1:0]       w_cnt_next;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_next;
    logic [BW-1:0]         r_byte_idx;
    logic [BW-1:0]         w_byte_next;
    logic [HW-1:0]         r_hold_cnt;
    logic [HW-1:0]         w_hold_next;
    // The captured word is shifted right one place per data bit, so bit 0 always holds
    // word_reg[8*byte_idx + bit_idx] for the bit currently on the line.
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_accept;
    logic                  w_bit_end;

    logic                  r_tx;
    logic                  r_done;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_done_next;
    logic                  w_busy_next;

    assign w_bit_end = (r_cnt == CNT_MAX);

    // State and datapath register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_hold_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_hold_cnt <= w_hold_next;
            r_shift    <= w_shift_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_hold_next  = r_hold_cnt;
        w_shift_next = r_shift;
        w_accept     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_accept = bus.tx_start;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = 3'd0;
                    w_next_state = S_DATA;
                end else begin
                    w_cnt_next = r_cnt + CNTW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = S_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNTW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_byte_idx == BYTE_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        // Next byte's start bit follows the stop bit with no idle gap.
                        w_byte_next  = r_byte_idx + BW'(1);
                        w_next_state = S_START;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNTW'(1);
                end
            end
            S_DONE: begin
                w_hold_next  = '0;
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_MAX) begin
                    // The edge that ends the holdoff is the re-entry to IDLE, so it also
                    // samples tx_start: a request held high is accepted here with no extra
                    // idle cycle, HOLDOFF+1 cycles after tx_done began.
                    w_next_state = S_IDLE;
                    w_accept     = bus.tx_start;
                end else begin
                    w_hold_next = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_accept) begin
            w_next_state = S_START;
            w_shift_next = bus.tx_data;
            w_cnt_next   = '0;
            w_bit_next   = 3'd0;
            w_byte_next  = '0;
        end
    end

    // Output decode from the next state, so the registered outputs line up with the state.
    always_comb begin
        w_tx_next   = 1'b1;
        w_done_next = 1'b0;
        w_busy_next = (w_next_state != S_IDLE);
        case (w_next_state)
            S_START: w_tx_next   = 1'b0;
            S_DATA:  w_tx_next   = w_shift_next[0];
            S_DONE:  w_done_next = 1'b1;
            default: w_tx_next   = 1'b1;
        endcase
    end

    // Output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_done <= w_done_next;
            r_busy <= w_busy_next;
        end
    end

    assign bus.tx      = r_tx;
    assign bus.tx_done = r_done;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   sel;
    logic mon_tx;
    logic mon_done;
    logic mon_busy;

    uart_word_tx_if #(.DATA_WIDTH(32)) if0 ();
    uart_word_tx_if #(.DATA_WIDTH(8))  if1 ();
    uart_word_tx_if #(.DATA_WIDTH(8))  if2 ();

    // Main instance: 32-bit word, 4 clocks per bit, holdoff 2.
    uart_word_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(4), .HOLDOFF(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );
    // Narrow/fast corner.
    uart_word_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .HOLDOFF(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );
    // Minimum holdoff.
    uart_word_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .HOLDOFF(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1:       begin mon_tx = if1.tx; mon_done = if1.tx_done; mon_busy = if1.busy; end
            2:       begin mon_tx = if2.tx; mon_done = if2.tx_done; mon_busy = if2.busy; end
            default: begin mon_tx = if0.tx; mon_done = if0.tx_done; mon_busy = if0.busy; end
        endcase
    end

    // Records one word from the selected line, starting at offset 0 (just after the accept
    // edge) and returning at offset nbytes*10*cpb, where tx_done is expected.
    task automatic sample_word(input int nbytes, input int cpb, output logic [31:0] word,
                               output int frame_errs, output int done_off, output int done_cnt);
        int total;
        int j;
        int k;
        total      = nbytes * 10 * cpb;
        word       = '0;
        frame_errs = 0;
        done_off   = -1;
        done_cnt   = 0;
        for (int i = 0; i <= total; i++) begin
            if (mon_done === 1'b1) begin
                done_cnt++;
                if (done_off < 0) done_off = i;
            end
            if (i < total && (i % cpb) == cpb / 2) begin
                j = i / cpb;
                k = j % 10;
                if (k == 0) begin
                    if (mon_tx !== 1'b0) frame_errs++;
                end else if (k == 9) begin
                    if (mon_tx !== 1'b1) frame_errs++;
                end else begin
                    word[(j / 10) * 8 + k - 1] = mon_tx;
                end
            end
            if (i < total) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut0 tx=%b busy=%b done=%b expected 1 0 0", if0.tx, if0.busy, if0.tx_done);
        end
        checks++;
        if (if1.tx !== 1'b1 || if1.busy !== 1'b0 || if2.tx !== 1'b1 || if2.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_corner tx1=%b busy1=%b tx2=%b busy2=%b expected 1 0 1 0",
                     if1.tx, if1.busy, if2.tx, if2.busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.tx_done !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d tx=%b busy=%b done=%b expected 1 0 0",
                         i, if0.tx, if0.busy, if0.tx_done);
            end
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        int fe, doff, dcnt;
        sel = 0;
        if0.tx_data  = 32'hA55A0F01;
        if0.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if0.tx_start = 1'b0;
        checks++;
        if (if0.tx !== 1'b0 || if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_accept tx=%b busy=%b expected 0 1", if0.tx, if0.busy);
        end
        sample_word(4, 4, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'hA55A0F01) begin
            failures++;
            $display("FAIL single_word got=%h expected a55a0f01", w);
        end
        checks++;
        if (fe !== 0) begin
            failures++;
            $display("FAIL single_framing bad_start_stop=%0d expected 0", fe);
        end
        checks++;
        if (doff !== 160 || dcnt !== 1) begin
            failures++;
            $display("FAIL single_done_time offset=%0d count=%0d expected 160 1", doff, dcnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if0.tx_done !== 1'b0 || if0.tx !== 1'b1) begin
            failures++;
            $display("FAIL single_done_width done=%b tx=%b expected 0 1", if0.tx_done, if0.tx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_hold busy=%b expected 1", if0.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_fall busy=%b expected 0", if0.busy);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int fe, doff, dcnt;
        sel = 0;
        if0.tx_data  = 32'h11223344;
        if0.tx_start = 1'b1;
        @(posedge clk);
        #1;
        sample_word(4, 4, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'h11223344 || fe !== 0 || doff !== 160) begin
            failures++;
            $display("FAIL b2b_first word=%h errs=%0d done_off=%0d expected 11223344 0 160", w, fe, doff);
        end
        @(posedge clk);
        #1;
        if0.tx_data = 32'hDEADBEEF;
        checks++;
        if (if0.tx_done !== 1'b0 || if0.tx !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_plus1 done=%b tx=%b expected 0 1", if0.tx_done, if0.tx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if0.tx !== 1'b1 || if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_plus2 tx=%b busy=%b expected 1 1", if0.tx, if0.busy);
        end
        @(posedge clk);
        #1;
        if0.tx_start = 1'b0;
        checks++;
        if (if0.tx !== 1'b0 || if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_recapture tx=%b busy=%b expected 0 1", if0.tx, if0.busy);
        end
        sample_word(4, 4, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'hDEADBEEF || fe !== 0 || doff !== 160 || dcnt !== 1) begin
            failures++;
            $display("FAIL b2b_second word=%h errs=%0d done_off=%0d cnt=%0d expected deadbeef 0 160 1",
                     w, fe, doff, dcnt);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_data_stability();
        logic [31:0] w;
        int fe, doff, dcnt;
        sel = 0;
        if0.tx_data  = 32'h0F0F1234;
        if0.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if0.tx_start = 1'b0;
        fork
            sample_word(4, 4, w, fe, doff, dcnt);
            begin
                for (int i = 0; i < 160; i++) begin
                    if0.tx_data = $urandom;
                    @(posedge clk);
                    #1;
                end
            end
        join
        checks++;
        if (w !== 32'h0F0F1234 || fe !== 0 || doff !== 160) begin
            failures++;
            $display("FAIL stability word=%h errs=%0d done_off=%0d expected 0f0f1234 0 160", w, fe, doff);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        int fe, doff, dcnt;
        int seen_done;
        sel = 0;
        seen_done = 0;
        if0.tx_data  = 32'h55AA33CC;
        if0.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if0.tx_start = 1'b0;
        // Offset 90 is inside the data bits of byte 2 (byte 2 starts at offset 80).
        repeat (90) @(posedge clk);
        #1;
        checks++;
        if (if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre busy=%b expected 1", if0.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.tx_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_now tx=%b busy=%b done=%b expected 1 0 0", if0.tx, if0.busy, if0.tx_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (if0.tx_done === 1'b1) seen_done++;
        end
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (if0.tx_done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL midreset_no_done pulses=%0d expected 0", seen_done);
        end
        if0.tx_data  = 32'h0BADF00D;
        if0.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if0.tx_start = 1'b0;
        sample_word(4, 4, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'h0BADF00D || fe !== 0 || doff !== 160 || dcnt !== 1) begin
            failures++;
            $display("FAIL midreset_after word=%h errs=%0d done_off=%0d cnt=%0d expected 0badf00d 0 160 1",
                     w, fe, doff, dcnt);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_narrow_corner();
        logic [31:0] w;
        int fe, doff, dcnt;
        sel = 1;
        #1;
        if1.tx_data  = 8'h80;
        if1.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if1.tx_start = 1'b0;
        sample_word(1, 2, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'h00000080 || fe !== 0) begin
            failures++;
            $display("FAIL narrow_word word=%h errs=%0d expected 00000080 0", w, fe);
        end
        checks++;
        if (doff !== 20 || dcnt !== 1) begin
            failures++;
            $display("FAIL narrow_done offset=%0d count=%0d expected 20 1", doff, dcnt);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_holdoff_one();
        logic [31:0] w;
        int fe, doff, dcnt;
        sel = 2;
        #1;
        if2.tx_data  = 8'h3C;
        if2.tx_start = 1'b1;
        @(posedge clk);
        #1;
        sample_word(1, 2, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'h0000003C || fe !== 0 || doff !== 20) begin
            failures++;
            $display("FAIL hold1_first word=%h errs=%0d done_off=%0d expected 0000003c 0 20", w, fe, doff);
        end
        @(posedge clk);
        #1;
        if2.tx_data = 8'hC3;
        checks++;
        if (if2.tx !== 1'b1 || if2.busy !== 1'b1 || if2.tx_done !== 1'b0) begin
            failures++;
            $display("FAIL hold1_done_plus1 tx=%b busy=%b done=%b expected 1 1 0", if2.tx, if2.busy, if2.tx_done);
        end
        @(posedge clk);
        #1;
        if2.tx_start = 1'b0;
        checks++;
        if (if2.tx !== 1'b0 || if2.busy !== 1'b1) begin
            failures++;
            $display("FAIL hold1_recapture tx=%b busy=%b expected 0 1", if2.tx, if2.busy);
        end
        sample_word(1, 2, w, fe, doff, dcnt);
        checks++;
        if (w !== 32'h000000C3 || fe !== 0 || doff !== 20) begin
            failures++;
            $display("FAIL hold1_second word=%h errs=%0d done_off=%0d expected 000000c3 0 20", w, fe, doff);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        sel          = 0;
        reset        = 1'b1;
        if0.tx_start = 1'b0;
        if0.tx_data  = '0;
        if1.tx_start = 1'b0;
        if1.tx_data  = '0;
        if2.tx_start = 1'b0;
        if2.tx_data  = '0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_narrow_corner();
        test_holdoff_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Serial transmit stage directly downstream of the debug send controller. It accepts a DATA_WIDTH-bit word on a level tx_start handshake and transmits it as DATA_WIDTH/8 consecutive 8N1 UART frames, least-significant byte first. It returns a one-cycle tx_done pulse when the whole word is on the line. A post-done holdoff gives the controller time to advance its address and register the next word before a new capture.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a non-zero multiple of 8; NBYTES = DATA_WIDTH/8.
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be >= 2.
HOLDOFF, 2, cycles spent in HOLD after tx_done before tx_start is sampled again; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
tx_start  input  1  level request; sampled only in IDLE.
tx_data  input  DATA_WIDTH  word to send; captured on the accept edge.
tx  output  1  serial line, registered, idle high.
tx_done  output  1  one-cycle pulse; word fully transmitted.
busy  output  1  high from the accept edge until re-entry to IDLE.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. While reset is asserted: tx=1, tx_done=0, busy=0, state=IDLE, all counters and the shift register are 0. Reset asserted mid-frame aborts the frame immediately; no tx_done is issued.
- States: IDLE, START, DATA, STOP, DONE, HOLD.
  - IDLE: tx=1. If tx_start=1 at an edge, that edge latches tx_data into word_reg, clears byte_idx and the baud counter, drives tx=0, and enters START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = word_reg[8*byte_idx + bit_idx]. Each bit is held for CLKS_PER_BIT cycles. After bit 7, enter STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if byte_idx < NBYTES-1, increment byte_idx and go to START. There is no idle gap between bytes. Otherwise go to DONE.
  - DONE: one cycle. tx_done=1, tx=1, then HOLD.
  - HOLD: HOLDOFF cycles with tx=1 and tx_start ignored, then IDLE.
- Timing: if the accept edge is t0, the first tx_done cycle begins at t0 + NBYTES*10*CLKS_PER_BIT. The earliest next accept edge is HOLDOFF+1 cycles after the tx_done cycle begins. A continuously high tx_start is therefore re-accepted at exactly that point.
- Width and arithmetic rules:
  - Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of each bit.
  - bit_idx is 3 bits. byte_idx is clog2(NBYTES) bits, with a minimum of 1.
- tx_data changes after the accept edge have no effect on the frame in progress. tx_start is ignored in every state except IDLE.
- tx_done is never asserted for two consecutive cycles and is never asserted outside DONE.
- busy = (state != IDLE).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then idle: with CLKS_PER_BIT=4, DATA_WIDTH=32, hold tx_start=0 for 100 cycles -> tx=1, busy=0, tx_done=0 throughout.
- Single word: tx_start one cycle with tx_data=0xA55A0F01 -> bytes 0x01, 0x0F, 0x5A, 0xA5 are sent LSB-first.
  - Each byte is framed 0,d0..d7,1, with every bit lasting 4 cycles.
  - tx_done pulses once, 160 cycles after the accept edge.
  - busy falls 3 cycles after the tx_done cycle.
- Level start back-to-back: hold tx_start=1 and change tx_data from 0x11223344 to 0xDEADBEEF one cycle after tx_done -> the second capture happens 3 cycles after tx_done and the second word is 0xDEADBEEF.
- Data stability: change tx_data every cycle during a frame -> the transmitted bits match the value captured on the accept edge.
- Reset mid-frame: assert reset during byte 2, DATA state -> tx=1, busy=0 immediately; tx_done never pulses. After release, a new word sends correctly.
- Parameter corners:
  - DATA_WIDTH=8, CLKS_PER_BIT=2, tx_data=0x80 -> a single frame 0,0000000,1,1; tx_done 20 cycles after accept.
  - HOLDOFF=1 -> re-accept 2 cycles after tx_done.
